// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers renamed ALU/branch ops, snoops the CDB for
// pending operands, and issues the oldest ready op to the ALU each cycle.
module alu_reservation_station #(
    parameter int ENTRIES_BITS = 2,
    parameter int ROBEN_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [ROBEN_W-1:0]      alloc_ROBEN,
    input  logic [11:0]             alloc_opcode,
    input  logic [3:0]              alloc_ALUOP,
    input  logic                    alloc_is_beq,
    input  logic                    alloc_is_bne,
    input  logic [31:0]             alloc_Vj,
    input  logic [31:0]             alloc_Vk,
    input  logic [ROBEN_W-1:0]      alloc_Qj,
    input  logic [ROBEN_W-1:0]      alloc_Qk,
    input  logic                    CDB_valid,
    input  logic [ROBEN_W-1:0]      CDB_ROBEN,
    input  logic [31:0]             CDB_res,
    input  logic                    FU_Is_Free,
    output logic                    ISSUE_valid,
    output logic [ROBEN_W-1:0]      ISSUE_ROBEN,
    output logic [11:0]             ISSUE_opcode,
    output logic [3:0]              ISSUE_ALUOP,
    output logic                    ISSUE_is_beq,
    output logic                    ISSUE_is_bne,
    output logic [31:0]             ISSUE_A,
    output logic [31:0]             ISSUE_B,
    output logic [ENTRIES_BITS:0]   RS_count
);

    localparam int ENTRIES = 1 << ENTRIES_BITS;
    localparam logic [ENTRIES_BITS:0]   FULL_COUNT = (ENTRIES_BITS + 1)'(ENTRIES);
    localparam logic [ENTRIES_BITS-1:0] RANK_ONE   = ENTRIES_BITS'(1);

    typedef struct packed {
        logic [ROBEN_W-1:0] roben;
        logic [11:0]        opcode;
        logic [3:0]         aluop;
        logic               beq;
        logic               bne;
        logic [31:0]        vj;
        logic [ROBEN_W-1:0] qj;
        logic [31:0]        vk;
        logic [ROBEN_W-1:0] qk;
    } entry_t;

    typedef struct packed {
        logic               valid;
        logic [ROBEN_W-1:0] roben;
        logic [11:0]        opcode;
        logic [3:0]         aluop;
        logic               beq;
        logic               bne;
        logic [31:0]        a;
        logic [31:0]        b;
    } issue_t;

    logic [ENTRIES-1:0]                   busy_q, busy_d;
    logic [ENTRIES-1:0][ENTRIES_BITS-1:0] rank_q, rank_d;
    entry_t [ENTRIES-1:0]                 ent_q, ent_d;
    issue_t                               iss_q, iss_d;

    logic [ENTRIES_BITS:0]   count;
    logic [ENTRIES-1:0]      ready;
    logic                    any_ready;
    logic [ENTRIES_BITS-1:0] sel_idx;
    logic [ENTRIES_BITS-1:0] sel_rank;
    logic [ENTRIES_BITS-1:0] free_idx;
    logic                    do_issue;
    logic                    do_alloc;
    logic                    cdb_hit_j;
    logic                    cdb_hit_k;

    // Occupancy, readiness, oldest-ready select and lowest free slot.
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count     = '0;
        ready     = '0;
        any_ready = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            count    = count + (ENTRIES_BITS + 1)'(busy_q[i]);
            ready[i] = busy_q[i] && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
            if (ready[i] && (!any_ready || rank_q[i] < sel_rank)) begin
                any_ready = 1'b1;
                sel_idx   = ENTRIES_BITS'(i);
                sel_rank  = rank_q[i];
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = ENTRIES_BITS'(i);
        end
    end

    assign alloc_ready = (count < FULL_COUNT);
    assign do_issue    = FU_Is_Free && any_ready && !flush;
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign cdb_hit_j   = CDB_valid && (CDB_ROBEN != '0) && (alloc_Qj == CDB_ROBEN);
    assign cdb_hit_k   = CDB_valid && (CDB_ROBEN != '0) && (alloc_Qk == CDB_ROBEN);

    // Next entry state: flush squashes everything, else wakeup, issue removal, allocate.
    always_comb begin
        busy_d = busy_q;
        rank_d = rank_q;
        ent_d  = ent_q;
        iss_d  = '0;
        if (flush) begin
            busy_d = '0;
            rank_d = '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && CDB_valid && CDB_ROBEN != '0) begin
                    if (ent_q[i].qj == CDB_ROBEN) begin
                        ent_d[i].vj = CDB_res;
                        ent_d[i].qj = '0;
                    end
                    if (ent_q[i].qk == CDB_ROBEN) begin
                        ent_d[i].vk = CDB_res;
                        ent_d[i].qk = '0;
                    end
                end
            end
            if (do_issue) begin
                iss_d.valid  = 1'b1;
                iss_d.roben  = ent_q[sel_idx].roben;
                iss_d.opcode = ent_q[sel_idx].opcode;
                iss_d.aluop  = ent_q[sel_idx].aluop;
                iss_d.beq    = ent_q[sel_idx].beq;
                iss_d.bne    = ent_q[sel_idx].bne;
                iss_d.a      = ent_q[sel_idx].vj;
                iss_d.b      = ent_q[sel_idx].vk;
                busy_d[sel_idx] = 1'b0;
                for (int i = 0; i < ENTRIES; i++) begin
                    if (busy_q[i] && rank_q[i] > sel_rank) rank_d[i] = rank_q[i] - RANK_ONE;
                end
            end
            if (do_alloc) begin
                busy_d[free_idx]       = 1'b1;
                rank_d[free_idx]       = ENTRIES_BITS'(count - (ENTRIES_BITS + 1)'(do_issue));
                ent_d[free_idx].roben  = alloc_ROBEN;
                ent_d[free_idx].opcode = alloc_opcode;
                ent_d[free_idx].aluop  = alloc_ALUOP;
                ent_d[free_idx].beq    = alloc_is_beq;
                ent_d[free_idx].bne    = alloc_is_bne;
                ent_d[free_idx].vj     = cdb_hit_j ? CDB_res : alloc_Vj;
                ent_d[free_idx].qj     = cdb_hit_j ? '0 : alloc_Qj;
                ent_d[free_idx].vk     = cdb_hit_k ? CDB_res : alloc_Vk;
                ent_d[free_idx].qk     = cdb_hit_k ? '0 : alloc_Qk;
            end
        end
    end

    // Control state and issue register, cleared by reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            rank_q <= '0;
            iss_q  <= '0;
        end else begin
            busy_q <= busy_d;
            rank_q <= rank_d;
            iss_q  <= iss_d;
        end
    end

    // Entry payload storage.
    // NOTE: payload is deliberately not reset; it is only ever read while its
    // busy bit is set, and busy is reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign ISSUE_valid  = iss_q.valid;
    assign ISSUE_ROBEN  = iss_q.roben;
    assign ISSUE_opcode = iss_q.opcode;
    assign ISSUE_ALUOP  = iss_q.aluop;
    assign ISSUE_is_beq = iss_q.beq;
    assign ISSUE_is_bne = iss_q.bne;
    assign ISSUE_A      = iss_q.a;
    assign ISSUE_B      = iss_q.b;
    assign RS_count     = count;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_ROBEN;
    logic [11:0] alloc_opcode;
    logic [3:0]  alloc_ALUOP;
    logic        alloc_is_beq;
    logic        alloc_is_bne;
    logic [31:0] alloc_Vj;
    logic [31:0] alloc_Vk;
    logic [4:0]  alloc_Qj;
    logic [4:0]  alloc_Qk;
    logic        CDB_valid;
    logic [4:0]  CDB_ROBEN;
    logic [31:0] CDB_res;
    logic        FU_Is_Free;
    logic        ISSUE_valid;
    logic [4:0]  ISSUE_ROBEN;
    logic [11:0] ISSUE_opcode;
    logic [3:0]  ISSUE_ALUOP;
    logic        ISSUE_is_beq;
    logic        ISSUE_is_bne;
    logic [31:0] ISSUE_A;
    logic [31:0] ISSUE_B;
    logic [2:0]  RS_count;

    int n_checks = 0;
    int n_fails  = 0;

    alu_reservation_station #(.ENTRIES_BITS(2), .ROBEN_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_ROBEN(alloc_ROBEN), .alloc_opcode(alloc_opcode), .alloc_ALUOP(alloc_ALUOP),
        .alloc_is_beq(alloc_is_beq), .alloc_is_bne(alloc_is_bne),
        .alloc_Vj(alloc_Vj), .alloc_Vk(alloc_Vk), .alloc_Qj(alloc_Qj), .alloc_Qk(alloc_Qk),
        .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_res(CDB_res),
        .FU_Is_Free(FU_Is_Free),
        .ISSUE_valid(ISSUE_valid), .ISSUE_ROBEN(ISSUE_ROBEN), .ISSUE_opcode(ISSUE_opcode),
        .ISSUE_ALUOP(ISSUE_ALUOP), .ISSUE_is_beq(ISSUE_is_beq), .ISSUE_is_bne(ISSUE_is_bne),
        .ISSUE_A(ISSUE_A), .ISSUE_B(ISSUE_B), .RS_count(RS_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: through the active edge, then settle to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an op; opcode/ALUOP/branch flags derive from the tag so a field
    // mix-up shows on the issue side.
    task automatic put(input logic [4:0] r, input logic [31:0] vj, input logic [4:0] qj,
                       input logic [31:0] vk, input logic [4:0] qk);
        alloc_valid  = 1'b1;
        alloc_ROBEN  = r;
        alloc_opcode = 12'h0B0 | {7'h0, r};
        alloc_ALUOP  = r[3:0];
        alloc_is_beq = r[0];
        alloc_is_bne = r[1];
        alloc_Vj     = vj;
        alloc_Qj     = qj;
        alloc_Vk     = vk;
        alloc_Qk     = qk;
    endtask

    task automatic expect_issue(input string tag, input logic [4:0] r, input logic [2:0] cnt);
        check({tag, "_valid"}, {31'h0, ISSUE_valid}, 32'h1);
        check({tag, "_roben"}, {27'h0, ISSUE_ROBEN}, {27'h0, r});
        check({tag, "_count"}, {29'h0, RS_count}, {29'h0, cnt});
    endtask

    task automatic expect_bubble(input string tag, input logic [2:0] cnt);
        check({tag, "_valid"}, {31'h0, ISSUE_valid}, 32'h0);
        check({tag, "_roben"}, {27'h0, ISSUE_ROBEN}, 32'h0);
        check({tag, "_count"}, {29'h0, RS_count}, {29'h0, cnt});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
        alloc_ROBEN = '0; alloc_opcode = '0; alloc_ALUOP = '0;
        alloc_is_beq = 1'b0; alloc_is_bne = 1'b0;
        alloc_Vj = '0; alloc_Vk = '0; alloc_Qj = '0; alloc_Qk = '0;
        CDB_valid = 1'b0; CDB_ROBEN = '0; CDB_res = '0; FU_Is_Free = 1'b1;

        // Reset state
        #12;
        expect_bubble("rst", 3'd0);
        check("rst_ready", {31'h0, alloc_ready}, 32'h1);
        check("rst_A", ISSUE_A, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: ready op issues one edge after allocation, never on its own edge
        put(5'd3, 32'd5, 5'd0, 32'd7, 5'd0);
        tick();
        alloc_valid = 1'b0;
        expect_bubble("t1_alloc", 3'd1);
        tick();
        expect_issue("t1_iss", 5'd3, 3'd0);
        check("t1_A", ISSUE_A, 32'd5);
        check("t1_B", ISSUE_B, 32'd7);
        check("t1_opcode", {20'h0, ISSUE_opcode}, 32'h0B3);
        check("t1_aluop", {28'h0, ISSUE_ALUOP}, 32'h3);
        check("t1_beq", {31'h0, ISSUE_is_beq}, 32'h1);
        check("t1_bne", {31'h0, ISSUE_is_bne}, 32'h1);
        tick();
        expect_bubble("t1_after", 3'd0);

        // 2: pending Qj woken by the CDB, issuable only one edge later
        put(5'd4, 32'd0, 5'd2, 32'h20, 5'd0);
        tick();
        alloc_valid = 1'b0;
        tick();
        expect_bubble("t2_wait", 3'd1);
        CDB_valid = 1'b1; CDB_ROBEN = 5'd2; CDB_res = 32'h10;
        tick();
        CDB_valid = 1'b0;
        expect_bubble("t2_wake", 3'd1);
        tick();
        expect_issue("t2_iss", 5'd4, 3'd0);
        check("t2_A", ISSUE_A, 32'h10);
        check("t2_B", ISSUE_B, 32'h20);

        // 3: same-cycle CDB capture at allocation
        put(5'd8, 32'd1, 5'd0, 32'd0, 5'd6);
        CDB_valid = 1'b1; CDB_ROBEN = 5'd6; CDB_res = 32'd9;
        tick();
        alloc_valid = 1'b0; CDB_valid = 1'b0;
        expect_bubble("t3_alloc", 3'd1);
        tick();
        expect_issue("t3_iss", 5'd8, 3'd0);
        check("t3_A", ISSUE_A, 32'd1);
        check("t3_B", ISSUE_B, 32'd9);

        // CDB tag 0 is ignored both at allocation and for a waiting entry
        FU_Is_Free = 1'b0;
        put(5'd9, 32'h11, 5'd0, 32'h22, 5'd0);
        CDB_valid = 1'b1; CDB_ROBEN = 5'd0; CDB_res = 32'hDEAD;
        tick();
        alloc_valid = 1'b0;
        tick();
        CDB_valid = 1'b0; FU_Is_Free = 1'b1;
        tick();
        expect_issue("z_iss", 5'd9, 3'd0);
        check("z_A", ISSUE_A, 32'h11);
        check("z_B", ISSUE_B, 32'h22);

        // 4: fill the station; full refuses allocation even on an issuing edge
        FU_Is_Free = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(5'(10 + i), 32'(i), 5'd0, 32'(i + 100), 5'd0);
            tick();
        end
        put(5'd14, 32'd0, 5'd0, 32'd0, 5'd0);
        check("t4_ready", {31'h0, alloc_ready}, 32'h0);
        check("t4_count", {29'h0, RS_count}, 32'd4);
        tick();
        expect_bubble("t4_stall", 3'd4);
        FU_Is_Free = 1'b1;
        tick();
        alloc_valid = 1'b0;
        expect_issue("t4_d10", 5'd10, 3'd3);
        tick();
        expect_issue("t4_d11", 5'd11, 3'd2);
        tick();
        expect_issue("t4_d12", 5'd12, 3'd1);
        check("t4_d12_B", ISSUE_B, 32'd102);
        tick();
        expect_issue("t4_d13", 5'd13, 3'd0);
        tick();
        expect_bubble("t4_empty", 3'd0);

        // 5: age order beats slot order after a slot is reused
        FU_Is_Free = 1'b0;
        put(5'd9, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        put(5'd5, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        put(5'd6, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        put(5'd7, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        alloc_valid = 1'b0;
        FU_Is_Free = 1'b1;
        tick();
        expect_issue("t5_i9", 5'd9, 3'd3);
        put(5'd15, 32'd0, 5'd0, 32'd0, 5'd0);
        tick();
        alloc_valid = 1'b0;
        expect_issue("t5_i5", 5'd5, 3'd3);
        check("t5_i5_beq", {31'h0, ISSUE_is_beq}, 32'h1);
        check("t5_i5_bne", {31'h0, ISSUE_is_bne}, 32'h0);
        tick();
        expect_issue("t5_i6", 5'd6, 3'd2);
        tick();
        expect_issue("t5_i7", 5'd7, 3'd1);
        tick();
        expect_issue("t5_i15", 5'd15, 3'd0);

        // 6: oldest ready first, then flush with three busy entries
        FU_Is_Free = 1'b0;
        put(5'd1, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        put(5'd2, 32'd0, 5'd0, 32'd0, 5'd0); tick();
        put(5'd3, 32'd0, 5'd30, 32'd0, 5'd0); tick();
        alloc_valid = 1'b0;
        check("t6_count", {29'h0, RS_count}, 32'd3);
        FU_Is_Free = 1'b1;
        tick();
        expect_issue("t6_i1", 5'd1, 3'd2);
        FU_Is_Free = 1'b0;
        put(5'd4, 32'd0, 5'd0, 32'd0, 5'd0);
        tick();
        expect_bubble("t6_refill", 3'd3);
        FU_Is_Free = 1'b1; flush = 1'b1;
        put(5'd5, 32'd0, 5'd0, 32'd0, 5'd0);
        tick();
        expect_bubble("t6_flush", 3'd0);
        flush = 1'b0; alloc_valid = 1'b0;
        tick();
        expect_bubble("t6_post", 3'd0);

        // Asynchronous reset mid-operation
        put(5'd7, 32'd0, 5'd0, 32'd0, 5'd0);
        tick();
        put(5'd8, 32'd0, 5'd3, 32'd0, 5'd0);
        tick();
        alloc_valid = 1'b0;
        expect_issue("ar_pre", 5'd7, 3'd1);
        #2 rst = 1'b1;
        #1;
        expect_bubble("ar_rst", 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        expect_bubble("ar_after", 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
